pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Registered program-counter unit for the MIPS32 fetch stage, successor to the combinational next-PC selector. Holds the PC, computes the next word address from branch/jump controls, and adds stall support and a parametrised return-address stack (RAS) that tracks `jal`/`jr` pairs. It either predicts `jr` targets or checks them. It sits between the control/ALU outputs and instruction memory.

## Interface
- `ADDR_W`, 12, width of the word-address field (PC bits `[ADDR_W+1:2]`)
- `PC_W`, 32, width of the PC output
- `RAS_DEPTH`, 4, number of RAS entries (≥2)
- `RAS_MODE`, 0, 0 = `jr` target is `jr_adress` and the RAS only checks it; 1 = `jr` target is the RAS top when non-empty
- `RESET_PC`, 0, PC value loaded on reset (word-aligned)

Ports:
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `stall` input 1: hold the PC and the RAS
- `j`, `jal`, `jr` inputs 1 each: jump controls
- `beq`, `bne`, `zero` inputs 1 each: branch controls and ALU zero flag
- `j_adress` input `ADDR_W`: absolute jump word address
- `jr_adress` input `ADDR_W`: register jump word address
- `b_adress` input `ADDR_W`: branch word offset, two's complement
- `pc` output `PC_W`: current PC (registered)
- `new_pc` output `PC_W`: next PC (combinational)
- `ras_count` output `$clog2(RAS_DEPTH+1)`: number of valid RAS entries
- `ras_empty`, `ras_full` outputs 1 each: RAS status
- `ras_miss` output 1: registered one-cycle pulse

## Operation
- Word address `w = pc[ADDR_W+1:2]`; `seq = w + 1`, modulo 2^ADDR_W.
- Branch is taken when `(beq & zero) | (bne & ~zero)`. Branch target = `seq + b_adress`, modulo 2^ADDR_W.
- Next-word priority: `j|jal` → `j_adress`; else `jr` → jr target; else branch taken → branch target; else `seq`.
- `new_pc`: bits `[PC_W-1:ADDR_W+2]` = 0, `[ADDR_W+1:2]` = next word, `[1:0]` = 0. With `stall`=1, `new_pc` = `pc`.
- RAS push:
  - Taken `jal` pushes `seq`.
  - When full, the push overwrites the oldest entry (circular); count stays `RAS_DEPTH`, `ras_full` stays 1.
- RAS pop:
  - `jr` that wins priority pops the top when non-empty. Popping an empty RAS leaves count 0.
- jr target:
  - `RAS_MODE`=1 and non-empty → popped value.
  - Otherwise → `jr_adress`.
- `ras_miss` is set for one cycle after a `jr` when:
  - the RAS was empty, or
  - the popped value ≠ `jr_adress`.
  - In mode 1 this tells control to flush.
- Simultaneous controls:
  - `jal` with `jr` → push only.
  - `j` with `jal` → treated as `jal`.
  - Branch is ignored under any jump.
- Stall: no PC update, no push/pop, `ras_miss` cleared.

## Timing
- Reset (async, `rst_n`=0): `pc`=`RESET_PC`, RAS emptied, `ras_count`=0, `ras_empty`=1, `ras_full`=0, `ras_miss`=0. Stored RAS entries are don't-care.
- Controls are sampled on the rising edge. `pc` equals the prior cycle's `new_pc`, so one-cycle latency.
- RAS update and `ras_miss` take effect at the same edge as `pc`.
- `ras_empty`/`ras_full` are decoded from the registered count. No combinational path exists from RAS state to `pc` in mode 0.
- Reset asserted mid-operation: immediate return to reset values. First update happens on the first edge after deassertion.

## Test plan
- Reset, then 3 idle cycles → `pc` = 0x0, 0x4, 0x8, 0xC; `ras_empty`=1.
- Branches at `pc`=0x10:
  - `beq`, `zero`=1, `b_adress`=3 → `pc`=0x20.
  - `bne`, `zero`=1 → `pc`=0x14.
  - `b_adress`=0xFFE with `beq` taken → `pc`=0xC.
- Wrap: `pc`=0x3FFC, idle → `pc`=0x0. Upper bits of `new_pc` stay 0 throughout.
- Call/return:
  - At `pc`=0x40, `jal`, `j_adress`=0x100 → `pc`=0x400, `ras_count`=1.
  - Then `jr`, `jr_adress`=0x11 → `pc`=0x44, `ras_count`=0, `ras_miss`=0.
  - Repeat with `jr_adress`=0x20, `RAS_MODE`=0 → `pc`=0x80, `ras_miss`=1 for one cycle.
- Overflow/underflow (`RAS_MODE`=1, depth 4):
  - 5 `jal`s from words 1..5 → count 4, `ras_full`=1.
  - 4 `jr`s return words 6,5,4,3.
  - 5th `jr` with `jr_adress`=0x7 → `pc`=0x1C, `ras_miss`=1.
- Stall and async reset:
  - `stall`=1 with `jal` → `pc` and `ras_count` unchanged.
  - Drop `rst_n` between edges → `pc`=`RESET_PC` immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered MIPS32 fetch-stage program counter with branch/jump
// selection, stall support and a circular return-address stack (RAS) that
// either checks (mode 0) or predicts (mode 1) jr targets.
module pc_sequencer #(
  parameter int              ADDR_W    = 12,
  parameter int              PC_W      = 32,
  parameter int              RAS_DEPTH = 4,
  parameter int              RAS_MODE  = 0,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             stall,
  input  logic                             j,
  input  logic                             jal,
  input  logic                             jr,
  input  logic                             beq,
  input  logic                             bne,
  input  logic                             zero,
  input  logic [ADDR_W-1:0]                j_adress,
  input  logic [ADDR_W-1:0]                jr_adress,
  input  logic [ADDR_W-1:0]                b_adress,
  output logic [PC_W-1:0]                  pc,
  output logic [PC_W-1:0]                  new_pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_empty,
  output logic                             ras_full,
  output logic                             ras_miss
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_W-1:0] word;
  logic [ADDR_W-1:0] seq_word;
  logic [ADDR_W-1:0] br_word;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] next_word;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  inc_ptr;
  logic              br_taken;
  logic              jr_wins;
  logic              push;
  logic              pop;
  logic              miss_next;
  logic [PC_W-1:0]   target_pc;

  assign word     = pc[ADDR_W+1:2];
  assign seq_word = word + 1'b1;
  assign br_word  = seq_word + b_adress;
  assign br_taken = (beq & zero) | (bne & ~zero);

  // jr only acts when no absolute jump (j/jal) claims priority
  assign jr_wins  = jr & ~j & ~jal;

  // wr_ptr points at the next free slot; the top of stack is the slot before it
  assign top_ptr  = (wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr - 1'b1;
  assign inc_ptr  = (wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign ras_top  = ras_mem[top_ptr];

  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

  assign push      = ~stall & jal;
  assign pop       = ~stall & jr_wins & ~ras_empty;
  assign miss_next = ~stall & jr_wins & (ras_empty | (ras_top != jr_adress));

  // jr target source: RAS prediction only in mode 1, register value otherwise
  always_comb begin
    jr_target = jr_adress;
    if (RAS_MODE == 1 && !ras_empty) begin
      jr_target = ras_top;
    end
  end

  // next-word priority: absolute jump, then jr, then taken branch, then sequential
  always_comb begin
    next_word = seq_word;
    if (j | jal) begin
      next_word = j_adress;
    end else if (jr) begin
      next_word = jr_target;
    end else if (br_taken) begin
      next_word = br_word;
    end
  end

  // place the next word in the PC word field, upper and byte bits zero; hold on stall
  always_comb begin
    target_pc = '0;
    target_pc[ADDR_W+1:2] = next_word;
    new_pc = stall ? pc : target_pc;
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= new_pc;
    end
  end

  // RAS pointer, occupancy and miss pulse; a full push overwrites the oldest slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      ras_count <= '0;
      ras_miss  <= 1'b0;
    end else begin
      ras_miss <= miss_next;
      if (push) begin
        wr_ptr <= inc_ptr;
        if (!ras_full) begin
          ras_count <= ras_count + 1'b1;
        end
      end else if (pop) begin
        wr_ptr    <= top_ptr;
        ras_count <= ras_count - 1'b1;
      end
    end
  end

  // RAS storage; contents are don't-care after reset so no reset is applied
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[wr_ptr] <= seq_word;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer, running a
// mode-0 (check) and a mode-1 (predict) instance from the same stimulus.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall, j, jal, jr, beq, bne, zero;
  logic [11:0] j_adress, jr_adress, b_adress;

  logic [31:0] pc0, new_pc0, pc1, new_pc1;
  logic [2:0]  cnt0, cnt1;
  logic        empty0, full0, miss0, empty1, full1, miss1;

  int checkCount = 0;
  int errorCount = 0;

  pc_sequencer #(.ADDR_W(12), .PC_W(32), .RAS_DEPTH(4), .RAS_MODE(0), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .j(j), .jal(jal), .jr(jr),
    .beq(beq), .bne(bne), .zero(zero),
    .j_adress(j_adress), .jr_adress(jr_adress), .b_adress(b_adress),
    .pc(pc0), .new_pc(new_pc0), .ras_count(cnt0),
    .ras_empty(empty0), .ras_full(full0), .ras_miss(miss0)
  );

  pc_sequencer #(.ADDR_W(12), .PC_W(32), .RAS_DEPTH(4), .RAS_MODE(1), .RESET_PC(32'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .j(j), .jal(jal), .jr(jr),
    .beq(beq), .bne(bne), .zero(zero),
    .j_adress(j_adress), .jr_adress(jr_adress), .b_adress(b_adress),
    .pc(pc1), .new_pc(new_pc1), .ras_count(cnt1),
    .ras_empty(empty1), .ras_full(full1), .ras_miss(miss1)
  );

  // free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic jj, input logic jl, input logic jrr,
                               input logic bq, input logic bn, input logic z,
                               input logic [11:0] ja, input logic [11:0] jra, input logic [11:0] ba);
    stall = s; j = jj; jal = jl; jr = jrr;
    beq = bq; bne = bn; zero = z;
    j_adress = ja; jr_adress = jra; b_adress = ba;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 12'h0);
    tick();
  endtask

  task automatic jumpTo(input logic [11:0] w);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, w, 12'h0, 12'h0);
    tick();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 12'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("reset pc0", pc0, 32'h0);
    checkOutput("reset pc1", pc1, 32'h0);
    checkOutput("reset count0", 32'(cnt0), 32'd0);
    checkOutput("reset empty1", 32'(empty1), 32'd1);
    checkOutput("reset full1", 32'(full1), 32'd0);
    checkOutput("reset miss0", 32'(miss0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 12'h0);
    #12;
    doReset();

    // sequential fetch after reset
    idle(); checkOutput("idle1 pc", pc0, 32'h4);
    idle(); checkOutput("idle2 pc", pc0, 32'h8);
    idle(); checkOutput("idle3 pc", pc0, 32'hC);
    checkOutput("idle empty", 32'(empty0), 32'd1);
    idle(); checkOutput("idle4 pc", pc0, 32'h10);

    // branches from 0x10
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 12'h0, 12'h0, 12'h003);
    #1; checkOutput("beq new_pc", new_pc0, 32'h20);
    tick(); checkOutput("beq taken pc", pc0, 32'h20);
    jumpTo(12'h004); checkOutput("j to 0x10", pc0, 32'h10);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 12'h0, 12'h0, 12'h003);
    tick(); checkOutput("bne not taken", pc0, 32'h14);
    jumpTo(12'h004);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 12'h0, 12'h0, 12'hFFE);
    tick(); checkOutput("beq negative", pc0, 32'hC);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h0, 12'h0, 12'h002);
    tick(); checkOutput("bne taken", pc0, 32'h18);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h0, 12'h0, 12'h002);
    tick(); checkOutput("beq not taken", pc0, 32'h1C);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 12'h030, 12'h0, 12'h003);
    tick(); checkOutput("j over branch", pc0, 32'hC0);

    // word-address wrap, upper bits stay zero
    jumpTo(12'hFFF); checkOutput("pc 0x3FFC", pc0, 32'h3FFC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 12'h0);
    #1; checkOutput("wrap new_pc", new_pc0, 32'h0);
    tick(); checkOutput("wrap pc", pc0, 32'h0);

    // call / return with matching register target
    jumpTo(12'h010); checkOutput("call site", pc0, 32'h40);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'h100, 12'h0, 12'h0);
    tick();
    checkOutput("jal pc", pc0, 32'h400);
    checkOutput("jal count0", 32'(cnt0), 32'd1);
    checkOutput("jal count1", 32'(cnt1), 32'd1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h0, 12'h011, 12'h0);
    tick();
    checkOutput("jr pc0", pc0, 32'h44);
    checkOutput("jr pc1", pc1, 32'h44);
    checkOutput("jr count0", 32'(cnt0), 32'd0);
    checkOutput("jr miss0", 32'(miss0), 32'd0);
    checkOutput("jr miss1", 32'(miss1), 32'd0);

    // call / return with mismatching register target
    jumpTo(12'h010);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'h100, 12'h0, 12'h0);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h0, 12'h020, 12'h0);
    tick();
    checkOutput("jr mismatch pc0", pc0, 32'h80);
    checkOutput("jr predict pc1", pc1, 32'h44);
    checkOutput("jr mismatch miss0", 32'(miss0), 32'd1);
    checkOutput("jr mismatch miss1", 32'(miss1), 32'd1);
    idle();
    checkOutput("miss pulse ends", 32'(miss0), 32'd0);
    checkOutput("after miss pc0", pc0, 32'h84);

    // simultaneous controls: jal+jr pushes only, j+jal acts as jal
    jumpTo(12'h010);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 12'h100, 12'h005, 12'h0);
    tick();
    checkOutput("jal+jr pc", pc0, 32'h400);
    checkOutput("jal+jr count", 32'(cnt0), 32'd1);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 12'h050, 12'h0, 12'h0);
    tick();
    checkOutput("j+jal pc", pc0, 32'h140);
    checkOutput("j+jal count", 32'(cnt1), 32'd2);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h0, 12'h101, 12'h0);
    tick();
    checkOutput("nested ret pc1", pc1, 32'h404);
    checkOutput("nested ret miss1", 32'(miss1), 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h0, 12'h011, 12'h0);
    tick();
    checkOutput("outer ret pc1", pc1, 32'h44);
    checkOutput("outer ret count", 32'(cnt1), 32'd0);

    // overflow / underflow of the 4-deep stack
    doReset();
    idle();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'(i + 1), 12'h0, 12'h0);
      tick();
      checkOutput("chain jal pc", pc1, 32'((i + 1) * 4));
    end
    checkOutput("overflow count", 32'(cnt1), 32'd4);
    checkOutput("overflow full", 32'(full1), 32'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h0, 12'h000, 12'h0);
      tick();
      checkOutput("ras return pc1", pc1, 32'((6 - k) * 4));
      checkOutput("ras return miss1", 32'(miss1), 32'd1);
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h0, 12'h007, 12'h0);
    tick();
    checkOutput("underflow pc1", pc1, 32'h1C);
    checkOutput("underflow miss1", 32'(miss1), 32'd1);
    checkOutput("underflow count", 32'(cnt1), 32'd0);
    checkOutput("underflow empty", 32'(empty1), 32'd1);

    // stall holds pc and RAS and clears the miss pulse
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 12'h200, 12'h0, 12'h0);
    #1; checkOutput("stall new_pc", new_pc1, 32'h1C);
    tick();
    checkOutput("stall pc", pc1, 32'h1C);
    checkOutput("stall count", 32'(cnt1), 32'd0);
    checkOutput("stall miss", 32'(miss1), 32'd0);

    // asynchronous reset between edges
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'h080, 12'h0, 12'h0);
    tick();
    checkOutput("pre-reset pc", pc1, 32'h200);
    checkOutput("pre-reset count", 32'(cnt1), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 12'h0, 12'h0, 12'h0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset pc", pc1, 32'h0);
    checkOutput("async reset count", 32'(cnt1), 32'd0);
    tick();
    checkOutput("held in reset pc", pc0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("first edge after reset", pc0, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
